// File: rtl/uart_rx_edge_bit_sampler.sv
// UART RX timing front end: edge/bit counters and
// 3-tap mid-bit majority sampler.
module uart_rx_edge_bit_sampler #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_In,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  Bit_Cnt_En,
  input  logic                  Data_Samp_En,
  output logic [PRESCALE_W-1:0] Edge_Cnt,
  output logic [BIT_CNT_W-1:0]  Bit_Cnt,
  output logic                  Sampled_Bit,
  output logic                  Sample_Valid,
  output logic                  Cfg_Err
);

  logic [PRESCALE_W-1:0] r_p_q;
  logic                  r_cfg_err;
  logic [PRESCALE_W-1:0] r_edge_cnt;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic                  r_tap0;
  logic                  r_tap1;
  logic                  r_sampled;
  logic                  r_valid;

  logic                  w_cfg_ok;
  logic                  w_run;
  logic [PRESCALE_W-1:0] w_half;
  logic [PRESCALE_W-1:0] w_last;
  logic [PRESCALE_W-1:0] w_tap0_pt;
  logic [PRESCALE_W-1:0] w_vote_pt;
  logic                  w_wrap;
  logic                  w_bit_max;
  logic                  w_sample;
  logic                  w_maj;

  assign w_cfg_ok  = (Prescale == PRESCALE_W'(8))
                  || (Prescale == PRESCALE_W'(16))
                  || (Prescale == PRESCALE_W'(32));
  assign w_run     = Bit_Cnt_En && !r_cfg_err;
  assign w_half    = r_p_q >> 1;
  assign w_last    = r_p_q - PRESCALE_W'(1);
  assign w_tap0_pt = w_half - PRESCALE_W'(1);
  assign w_vote_pt = w_half + PRESCALE_W'(1);
  assign w_wrap    = (r_edge_cnt == w_last);
  assign w_bit_max = &r_bit_cnt;
  assign w_sample  = w_run && Data_Samp_En;
  assign w_maj     = (r_tap0 & r_tap1)
                  | (r_tap0 & RX_In)
                  | (r_tap1 & RX_In);

  // Latch prescale and its legality between frames only
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_p_q     <= PRESCALE_W'(8);
      r_cfg_err <= 1'b0;
    end else if (!Bit_Cnt_En) begin
      r_p_q     <= Prescale;
      r_cfg_err <= !w_cfg_ok;
    end
  end

  // Edge counter within a bit, saturating bit counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (!w_run) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (w_wrap) begin
      r_edge_cnt <= '0;
      if (!w_bit_max)
        r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
    end else begin
      r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
    end
  end

  // Mid-bit taps and majority vote with one-cycle valid pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tap0    <= 1'b1;
      r_tap1    <= 1'b1;
      r_sampled <= 1'b1;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!Bit_Cnt_En) begin
        r_tap0 <= 1'b1;
        r_tap1 <= 1'b1;
      end else if (w_sample) begin
        if (r_edge_cnt == w_tap0_pt)
          r_tap0 <= RX_In;
        if (r_edge_cnt == w_half)
          r_tap1 <= RX_In;
        if (r_edge_cnt == w_vote_pt) begin
          r_sampled <= w_maj;
          r_valid   <= 1'b1;
        end
      end
    end
  end

  assign Edge_Cnt     = r_edge_cnt;
  assign Bit_Cnt      = r_bit_cnt;
  assign Sampled_Bit  = r_sampled;
  assign Sample_Valid = r_valid;
  assign Cfg_Err      = r_cfg_err;

endmodule
